gray_counter: RTL and testbench

//  Registered up/down counter producing a binary count and its Gray-coded equivalent from flops.

---
 rtl/gray_pkg.sv | 27 ++
 rtl/gray_counter.sv | 68 ++++++
 tb/tb_gray_counter.sv | 152 +++++++++++++++
 3 files changed

// File: rtl/gray_pkg.sv
// Shared helpers for Gray-code counters and their benches.
// Functions work on a fixed 32-bit word; callers cast to their own width.
package gray_pkg;

    localparam int MAXW = 32;

    typedef logic [MAXW-1:0] word_t;

    function automatic word_t bin2gray(input word_t b);
        return b ^ (b >> 1);
    endfunction

    // Prefix XOR from the MSB down recovers the binary value.
    function automatic word_t gray2bin(input word_t g);
        word_t b;
        b = g;
        for (int s = 1; s < MAXW; s = s * 2) begin
            b = b ^ (b >> s);
        end
        return b;
    endfunction

    function automatic logic onehot_chk(input word_t v);
        return (v != '0) && ((v & (v - word_t'(1))) == '0);
    endfunction

endpackage

// File: rtl/gray_counter.sv
// Up/down counter with registered binary and Gray outputs,
// terminal-count pulse and a sticky single-bit-step monitor.
module gray_counter
    import gray_pkg::*;
#(
    parameter int               WIDTH = 4,
    parameter logic [WIDTH-1:0] INIT  = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             up_dn,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] bin_out,
    output logic [WIDTH-1:0] gray_out,
    output logic             tc,
    output logic             step_err
);

    localparam logic [WIDTH-1:0] GINIT = WIDTH'(bin2gray(MAXW'(INIT)));

    logic [WIDTH-1:0] bin_q, bin_d;
    logic [WIDTH-1:0] gray_q, gray_d;
    logic             tc_q, tc_d;
    logic             err_q, err_d;
    logic [WIDTH-1:0] step;

    always_comb begin
        bin_d  = bin_q;
        gray_d = gray_q;
        tc_d   = 1'b0;
        err_d  = err_q;
        step   = up_dn ? bin_q + WIDTH'(1) : bin_q - WIDTH'(1);
        if (load) begin
            bin_d  = load_val;
            gray_d = WIDTH'(bin2gray(MAXW'(load_val)));
        end else if (en) begin
            bin_d  = step;
            gray_d = WIDTH'(bin2gray(MAXW'(step)));
            tc_d   = up_dn ? (&bin_q) : ~(|bin_q);
            // Gray is taken from the next count, so any multi-bit step is a fault
            if (!onehot_chk(MAXW'(gray_d ^ gray_q))) begin
                err_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            bin_q  <= INIT;
            gray_q <= GINIT;
            tc_q   <= 1'b0;
            err_q  <= 1'b0;
        end else begin
            bin_q  <= bin_d;
            gray_q <= gray_d;
            tc_q   <= tc_d;
            err_q  <= err_d;
        end
    end

    assign bin_out  = bin_q;
    assign gray_out = gray_q;
    assign tc       = tc_q;
    assign step_err = err_q;

endmodule

// File: tb/tb_gray_counter.sv
// Self-checking bench for gray_counter (WIDTH=4, INIT=0).
// Arithmetic reference model plus literal spot checks.
module tb_gray_counter;
    import gray_pkg::*;

    localparam int W = 4;
    localparam int M = 1 << W;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         en = 1'b0;
    logic         up_dn = 1'b0;
    logic         load = 1'b0;
    logic [W-1:0] load_val = '0;
    logic [W-1:0] bin_out;
    logic [W-1:0] gray_out;
    logic         tc;
    logic         step_err;

    int errors = 0;
    int checks = 0;
    bit chk_en = 1'b0;

    int m_bin = 0;
    int m_tc = 0;

    gray_counter #(.WIDTH(W), .INIT('0)) dut (
        .clk(clk),
        .rst(rst),
        .en(en),
        .up_dn(up_dn),
        .load(load),
        .load_val(load_val),
        .bin_out(bin_out),
        .gray_out(gray_out),
        .tc(tc),
        .step_err(step_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Drive one cycle, advance the model at the edge, settle past it.
    task automatic cyc(input bit r, input bit e, input bit u,
                       input bit l, input int lv);
        rst = r;
        en = e;
        up_dn = u;
        load = l;
        load_val = W'(lv);
        @(posedge clk);
        if (r) begin
            m_bin = 0;
            m_tc = 0;
        end else if (l) begin
            m_bin = lv % M;
            m_tc = 0;
        end else if (e) begin
            if (u) begin
                m_tc = (m_bin == M - 1) ? 1 : 0;
                m_bin = (m_bin + 1) % M;
            end else begin
                m_tc = (m_bin == 0) ? 1 : 0;
                m_bin = (m_bin + M - 1) % M;
            end
        end else begin
            m_tc = 0;
        end
        #1;
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            chk("bin", int'(bin_out), m_bin);
            chk("gray", int'(gray_out), m_bin ^ (m_bin / 2));
            chk("g2b", int'(W'(gray2bin(32'(gray_out)))), int'(bin_out));
            chk("tc", int'(tc), m_tc);
            chk("step_err", int'(step_err), 0);
        end
    end

    initial begin
        int gseq[17];
        gseq = '{'h0, 'h1, 'h3, 'h2, 'h6, 'h7, 'h5, 'h4, 'hC,
                 'hD, 'hF, 'hE, 'hA, 'hB, 'h9, 'h8, 'h0};

        cyc(1, 0, 0, 0, 0);
        chk_en = 1'b1;
        chk("rst_bin", int'(bin_out), 0);
        chk("rst_gray", int'(gray_out), 0);
        chk("rst_tc", int'(tc), 0);
        chk("rst_err", int'(step_err), 0);

        for (int i = 0; i < 16; i++) begin
            cyc(0, 1, 1, 0, 0);
            chk("up_gray_lit", int'(gray_out), gseq[i+1]);
            chk("up_tc_lit", int'(tc), (i == 15) ? 1 : 0);
        end

        cyc(1, 0, 0, 0, 0);
        cyc(0, 1, 0, 0, 0);
        chk("dn_bin_lit", int'(bin_out), 'hF);
        chk("dn_gray_lit", int'(gray_out), 'h8);
        chk("dn_tc_lit", int'(tc), 1);
        cyc(0, 1, 0, 0, 0);
        chk("dn2_bin_lit", int'(bin_out), 'hE);
        chk("dn2_gray_lit", int'(gray_out), 'h9);
        chk("dn2_tc_lit", int'(tc), 0);

        cyc(0, 1, 1, 1, 'hA);
        chk("ld_bin_lit", int'(bin_out), 'hA);
        chk("ld_gray_lit", int'(gray_out), 'hF);
        chk("ld_tc_lit", int'(tc), 0);

        cyc(0, 0, 0, 1, 7);
        for (int i = 0; i < 4; i++) begin
            cyc(0, 1, (i % 2 == 0), 0, 0);
            chk("alt_gray_lit", int'(gray_out), (i % 2 == 0) ? 'hC : 'h4);
        end
        cyc(0, 0, 1, 0, 0);
        chk("hold_bin_lit", int'(bin_out), 7);

        cyc(1, 0, 0, 0, 0);
        for (int i = 0; i < 9; i++) cyc(0, 1, 1, 0, 0);
        chk("cnt9_lit", int'(bin_out), 9);
        cyc(1, 1, 1, 1, 5);
        chk("mid_rst_bin", int'(bin_out), 0);
        chk("mid_rst_gray", int'(gray_out), 0);
        chk("mid_rst_tc", int'(tc), 0);

        for (int i = 0; i < 10000; i++) begin
            cyc(($urandom % 512) == 0,
                ($urandom % 4) != 0,
                ($urandom % 2) == 1,
                ($urandom % 16) == 0,
                int'($urandom % M));
        end

        @(negedge clk);
        chk_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
